scr1_tcm_portb_arbiter: RTL and testbench
=========================================

// Module: scr1_tcm_portb_arbiter
// PURPOSE
// - Shares TCM port B (read/write, byte-enabled, 1-cycle registered read) between two requesters:
//   req0 = core data interface, req1 = host/debug program loader.
// - Optional post-reset clear sequencer zero-fills the whole TCM before any grant is issued.
// - Sits between the requesters and scr1_dp_memory port B; port A (instruction fetch) is untouched.
// PARAMETERS
// - SCR1_WIDTH      32       data width; must be 32 (4 byte lanes)
// - SCR1_SIZE       65536    memory size in bytes; AW = $clog2(SCR1_SIZE), word address = [AW-1:2]
// - CLEAR_ON_RESET  1        1: run clear sequence after reset; 0: enter ARB directly
// PORTS
// - clk          in   1        single clock, all logic posedge
// - rst          in   1        synchronous reset, active-high
// - rN_req       in   1        requester N (N=0,1) access request; held with fields stable until rN_gnt
// - rN_we        in   1        1 = write, 0 = read
// - rN_be        in   4        write byte enables
// - rN_addr      in   AW-2     word address
// - rN_wdata     in   32       write data
// - rN_gnt       out  1        access accepted this cycle (combinational from req and state)
// - rN_rvalid    out  1        read data valid; exactly 1 cycle after a read grant
// - rN_rdata     out  32       read data (= mem_rdata; meaningful only while rN_rvalid)
// - mem_renb     out  1        to port B renb
// - mem_wenb     out  1        to port B wenb
// - mem_webb     out  4        to port B webb
// - mem_addrb    out  AW-2     to port B addrb
// - mem_datab    out  32       to port B datab
// - mem_qb       in   32       from port B qb
// - init_done    out  1        clear sequence complete; high while in ARB
// BEHAVIOUR
// - Reset values: all rN_gnt/rN_rvalid 0, mem_renb/mem_wenb 0, mem_webb 0, init_done 0, rr pointer -> req0.
// - FSM: CLEAR -> ARB. Reset (any cycle, any state) forces CLEAR (or ARB if CLEAR_ON_RESET=0).
// - CLEAR: counter cnt from 0; each cycle mem_wenb=1, mem_webb=4'hF, mem_datab=0, mem_addrb=cnt;
//   no grants. After cnt = WORDS-1 (WORDS = SCR1_SIZE/4) -> ARB next cycle; clear takes WORDS cycles.
// - ARB: at most one grant per cycle. Only one req -> grant it. Both req -> grant the one not granted
//   last (round-robin pointer updates on every grant). No req -> mem_renb=mem_wenb=0.
// - Granted access drives mem_* same cycle: read -> mem_renb=1; write -> mem_wenb=1, mem_webb=rN_be.
// - Read latency 1: rvalid registered, asserted to the granted requester the cycle after grant;
//   back-to-back reads from either requester allowed every cycle (no bubbles).
// - Write with rN_be=0: granted, mem_wenb=1, memory unchanged. Writes produce no rvalid.
// - rst during in-flight read: rvalid of that read is suppressed (rvalid 0 the next cycle).
// - Ungranted requester sees gnt=0 and must hold; no starvation: max wait 1 cycle under contention.
// STRUCTURE
// - Package scr1_tcm_arb_pkg: typedef enum logic {ARB_CLEAR, ARB_RUN} tcm_arb_state_e;
//   typedef enum logic {REQ_CORE, REQ_LOADER} tcm_arb_req_e; localparam TCM_ARB_NREQ = 2.
// - One sub-module: scr1_rr_arb2 (2-way round-robin: req[1:0], advance, gnt[1:0], onehot output).
// - Top holds FSM, clear counter, port-B mux, rvalid/owner pipeline register.
// TESTING (bench: SCR1_SIZE=64 -> 16 words, memory model = scr1_dp_memory port B)
// - Reset release, CLEAR_ON_RESET=1: mem_wenb high 16 cycles, addrb 0..15, datab 0; init_done on cycle 17;
//   r0_req held throughout -> r0_gnt first seen cycle 17.
// - r0 write addr 3 data 32'hDEADBEEF be 4'hF, then r0 read addr 3 -> r0_rvalid 1 cycle after gnt,
//   r0_rdata = 32'hDEADBEEF; r1_rvalid stays 0.
// - Byte lanes: r1 write addr 5 data 32'h11223344 be 4'hF, then be 4'b0010 data 32'h0000AA00,
//   read -> 32'h1122AA44.
// - Contention: r0 and r1 reading addr 1 and 2 continuously 6 cycles -> grants alternate 0,1,0,1,0,1
//   starting with r0; each rvalid on matching requester one cycle later, no idle mem cycles.
// - rst asserted in cycle of a read grant -> no rvalid next cycle; clear restarts at addr 0;
//   prior contents read back as 0 afterwards.
// - CLEAR_ON_RESET=0: init_done 1 the cycle after rst deasserts; r1 read granted in that cycle.

Source files
------------

// File: rtl/scr1_tcm_portb_arbiter_pkg.sv
// scr1_tcm_arb_pkg: shared types and constants for the TCM port-B arbiter
// No ports. Holds the FSM state enum, the requester index enum and the requester count.
package scr1_tcm_arb_pkg;
    typedef enum logic {ARB_CLEAR, ARB_RUN} tcm_arb_state_e;
    typedef enum logic {REQ_CORE, REQ_LOADER} tcm_arb_req_e;
    localparam int TCM_ARB_NREQ = 2;
endpackage

// File: rtl/scr1_tcm_portb_arbiter_if.sv
// scr1_tcm_portb_arbiter_if: requester and TCM port-B bus bundle
// Requester N (N=0 core, N=1 loader): req/we/be/addr/wdata in, gnt/rvalid/rdata out.
// Memory side: renb/wenb/webb/addrb/datab out to port B, qb back from port B.
// slave = arbiter view, master = requesters + memory view.
interface scr1_tcm_portb_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic              r0_req, r0_we, r0_gnt, r0_rvalid;
    logic [DW/8-1:0]   r0_be;
    logic [AW-3:0]     r0_addr;
    logic [DW-1:0]     r0_wdata, r0_rdata;
    logic              r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [DW/8-1:0]   r1_be;
    logic [AW-3:0]     r1_addr;
    logic [DW-1:0]     r1_wdata, r1_rdata;
    logic              mem_renb, mem_wenb;
    logic [DW/8-1:0]   mem_webb;
    logic [AW-3:0]     mem_addrb;
    logic [DW-1:0]     mem_datab, mem_qb;
    modport slave (
        input  r0_req, r0_we, r0_be, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_be, r1_addr, r1_wdata, mem_qb,
        output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
        output mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab
    );
    modport master (
        output r0_req, r0_we, r0_be, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_be, r1_addr, r1_wdata, mem_qb,
        input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
        input  mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab
    );
endinterface

// File: rtl/scr1_tcm_portb_arbiter_rr.sv
// scr1_rr_arb2: two-way round-robin arbiter with one-hot grant
// Ports: clk, rst, req[1:0] requests, advance (grant is consumed), gnt[1:0] one-hot grant.
module scr1_rr_arb2
    import scr1_tcm_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TCM_ARB_NREQ-1:0] req,
    input  logic                    advance,
    output logic [TCM_ARB_NREQ-1:0] gnt
);
    // prio_q names the requester that wins the next tie
    tcm_arb_req_e prio_q, prio_d;
    always_comb begin
        gnt = (req[REQ_CORE] && (!req[REQ_LOADER] || prio_q == REQ_CORE)) ? 2'b01 :
              req[REQ_LOADER] ? 2'b10 : 2'b00;
        prio_d = (advance && |gnt) ? (gnt[REQ_CORE] ? REQ_LOADER : REQ_CORE) : prio_q;
    end
    always_ff @(posedge clk) begin
        if (rst) prio_q <= REQ_CORE;
        else     prio_q <= prio_d;
    end
endmodule

// File: rtl/scr1_tcm_portb_arbiter.sv
// scr1_tcm_portb_arbiter: shares TCM port B between core data and loader, with post-reset clear
// Ports: clk, rst (sync, active-high), bus (requester + port-B signals, slave modport),
// init_done (high while arbitrating, i.e. after the clear sequence).
module scr1_tcm_portb_arbiter
    import scr1_tcm_arb_pkg::*;
#(
    parameter int SCR1_WIDTH     = 32,
    parameter int SCR1_SIZE      = 65536,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    scr1_tcm_portb_arbiter_if.slave  bus,
    output logic                     init_done
);
    localparam int CW = $clog2(SCR1_SIZE) - 2;
    localparam int NB = SCR1_WIDTH / 8;
    localparam logic [CW-1:0] LAST = CW'(SCR1_SIZE / 4 - 1);
    localparam tcm_arb_state_e RST_STATE = CLEAR_ON_RESET ? ARB_CLEAR : ARB_RUN;
    tcm_arb_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TCM_ARB_NREQ-1:0] rvalid_q, rvalid_d, req, gnt;
    logic run, clr, sel, we, acc;
    // Outputs are forced idle while rst is held so the port sees no traffic during reset
    assign run = state_q == ARB_RUN && !rst;
    assign clr = state_q == ARB_CLEAR && !rst;
    assign req = {bus.r1_req, bus.r0_req} & {TCM_ARB_NREQ{run}};
    scr1_rr_arb2 u_rr (.clk(clk), .rst(rst), .req(req), .advance(run), .gnt(gnt));
    always_comb begin
        sel = gnt[REQ_LOADER];
        acc = |gnt;
        we = sel ? bus.r1_we : bus.r0_we;
        state_d = (clr && cnt_q == LAST) ? ARB_RUN : state_q;
        cnt_d = clr ? cnt_q + 1'b1 : '0;
        rvalid_d = we ? '0 : gnt;
        bus.r0_gnt = gnt[REQ_CORE];
        bus.r1_gnt = gnt[REQ_LOADER];
        bus.r0_rvalid = rvalid_q[REQ_CORE];
        bus.r1_rvalid = rvalid_q[REQ_LOADER];
        bus.r0_rdata = bus.mem_qb;
        bus.r1_rdata = bus.mem_qb;
        bus.mem_renb = acc && !we;
        bus.mem_wenb = clr || (acc && we);
        bus.mem_webb = clr ? {NB{1'b1}} : (acc && we) ? (sel ? bus.r1_be : bus.r0_be) : '0;
        bus.mem_addrb = clr ? cnt_q : sel ? bus.r1_addr : bus.r0_addr;
        bus.mem_datab = clr ? '0 : sel ? bus.r1_wdata : bus.r0_wdata;
        init_done = run;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_scr1_tcm_portb_arbiter.sv
// tb_scr1_tcm_portb_arbiter: directed bench for the TCM port-B arbiter with a port-B memory model
module tb_scr1_tcm_portb_arbiter;
    logic clk = 1'b0, rst = 1'b1, fill = 1'b1, done0, done1;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] mem [16];

    always #5 clk = ~clk;

    scr1_tcm_portb_arbiter_if #(.AW(6), .DW(32)) a ();
    scr1_tcm_portb_arbiter_if #(.AW(6), .DW(32)) b ();

    scr1_tcm_portb_arbiter #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .CLEAR_ON_RESET(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(a), .init_done(done0));
    scr1_tcm_portb_arbiter #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .CLEAR_ON_RESET(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(b), .init_done(done1));

    // Port-B model: registered read, byte-lane writes; fill preloads garbage so clearing is visible
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + i;
        end else begin
            if (a.mem_renb) a.mem_qb <= mem[a.mem_addrb];
            if (a.mem_wenb)
                for (int k = 0; k < 4; k++)
                    if (a.mem_webb[k]) mem[a.mem_addrb][k*8 +: 8] <= a.mem_datab[k*8 +: 8];
        end
    end

    typedef struct {
        logic q0, w0; logic [3:0] b0, a0; logic [31:0] d0;
        logic q1, w1; logic [3:0] b1, a1; logic [31:0] d1;
        logic [1:0] gnt, rv; logic ren, wen; logic [31:0] rd;
    } vec_t;
    vec_t tv [18];

    function automatic vec_t mk(
        input logic q0, input logic w0, input logic [3:0] b0, input logic [3:0] a0, input logic [31:0] d0,
        input logic q1, input logic w1, input logic [3:0] b1, input logic [3:0] a1, input logic [31:0] d1,
        input logic [1:0] gnt, input logic [1:0] rv, input logic ren, input logic wen, input logic [31:0] rd);
        vec_t v;
        v.q0 = q0; v.w0 = w0; v.b0 = b0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.b1 = b1; v.a1 = a1; v.d1 = d1;
        v.gnt = gnt; v.rv = rv; v.ren = ren; v.wen = wen; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        a.r0_req = v.q0; a.r0_we = v.w0; a.r0_be = v.b0; a.r0_addr = v.a0; a.r0_wdata = v.d0;
        a.r1_req = v.q1; a.r1_we = v.w1; a.r1_be = v.b1; a.r1_addr = v.a1; a.r1_wdata = v.d1;
    endtask

    initial begin
        // cycle 18 onwards; r0 read of addr 0 was granted in cycle 17
        tv[0]  = mk(1,1,4'hF,3,32'hDEADBEEF, 0,0,0,0,0,           2'b01,2'b01,0,1,32'h0);
        tv[1]  = mk(1,0,0,3,0,               0,0,0,0,0,           2'b01,2'b00,1,0,0);
        tv[2]  = mk(0,0,0,0,0,               0,0,0,0,0,           2'b00,2'b01,0,0,32'hDEADBEEF);
        tv[3]  = mk(0,0,0,0,0,               1,1,4'hF,5,32'h11223344, 2'b10,2'b00,0,1,0);
        tv[4]  = mk(0,0,0,0,0,               1,1,4'h2,5,32'h0000AA00, 2'b10,2'b00,0,1,0);
        tv[5]  = mk(0,0,0,0,0,               1,0,0,5,0,           2'b10,2'b00,1,0,0);
        tv[6]  = mk(0,0,0,0,0,               1,1,4'h0,5,32'hFFFFFFFF, 2'b10,2'b10,0,1,32'h1122AA44);
        tv[7]  = mk(0,0,0,0,0,               1,0,0,5,0,           2'b10,2'b00,1,0,0);
        tv[8]  = mk(0,0,0,0,0,               0,0,0,0,0,           2'b00,2'b10,0,0,32'h1122AA44);
        tv[9]  = mk(1,1,4'hF,1,32'h11110001, 1,1,4'hF,2,32'h22220002, 2'b01,2'b00,0,1,0);
        tv[10] = mk(0,0,0,0,0,               1,1,4'hF,2,32'h22220002, 2'b10,2'b00,0,1,0);
        tv[11] = mk(1,0,0,1,0,               1,0,0,2,0,           2'b01,2'b00,1,0,0);
        tv[12] = mk(1,0,0,1,0,               1,0,0,2,0,           2'b10,2'b01,1,0,32'h11110001);
        tv[13] = mk(1,0,0,1,0,               1,0,0,2,0,           2'b01,2'b10,1,0,32'h22220002);
        tv[14] = mk(1,0,0,1,0,               1,0,0,2,0,           2'b10,2'b01,1,0,32'h11110001);
        tv[15] = mk(1,0,0,1,0,               1,0,0,2,0,           2'b01,2'b10,1,0,32'h22220002);
        tv[16] = mk(1,0,0,1,0,               1,0,0,2,0,           2'b10,2'b01,1,0,32'h11110001);
        tv[17] = mk(0,0,0,0,0,               0,0,0,0,0,           2'b00,2'b10,0,0,32'h22220002);

        drive(mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
        b.r0_req = 0; b.r0_we = 0; b.r0_be = 0; b.r0_addr = 0; b.r0_wdata = 0;
        b.r1_req = 1; b.r1_we = 0; b.r1_be = 0; b.r1_addr = 0; b.r1_wdata = 0; b.mem_qb = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.gnt", {a.r1_gnt, a.r0_gnt}, 0);
        chk("rst.rvalid", {a.r1_rvalid, a.r0_rvalid}, 0);
        chk("rst.en", {a.mem_renb, a.mem_wenb}, 0);
        chk("rst.webb", a.mem_webb, 0);
        chk("rst.done", {done1, done0}, 0);
        chk("rst.b_gnt", b.r1_gnt, 0);

        @(negedge clk);
        rst = 1'b0;
        fill = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk($sformatf("clr%0d.wenb", k), a.mem_wenb, 1);
            chk($sformatf("clr%0d.addr", k), a.mem_addrb, k - 1);
            if (k == 1 || k == 16) begin
                chk($sformatf("clr%0d.data", k), a.mem_datab, 0);
                chk($sformatf("clr%0d.webb", k), a.mem_webb, 4'hF);
            end
            chk($sformatf("clr%0d.gnt", k), {a.r1_gnt, a.r0_gnt}, 0);
            chk($sformatf("clr%0d.done", k), done0, 0);
            if (k == 1) begin
                chk("noclr.done", done1, 1);
                chk("noclr.r1_gnt", b.r1_gnt, 1);
                chk("noclr.renb", b.mem_renb, 1);
            end
            @(negedge clk);
        end
        #1;
        chk("c17.done", done0, 1);
        chk("c17.r0_gnt", a.r0_gnt, 1);
        chk("c17.renb", {a.mem_renb, a.mem_wenb}, 2'b10);

        for (int i = 0; i < $size(tv); i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("v%0d.gnt", i), {a.r1_gnt, a.r0_gnt}, tv[i].gnt);
            chk($sformatf("v%0d.rvalid", i), {a.r1_rvalid, a.r0_rvalid}, tv[i].rv);
            chk($sformatf("v%0d.en", i), {a.mem_renb, a.mem_wenb}, {tv[i].ren, tv[i].wen});
            if (tv[i].rv[0]) chk($sformatf("v%0d.r0_rdata", i), a.r0_rdata, tv[i].rd);
            if (tv[i].rv[1]) chk($sformatf("v%0d.r1_rdata", i), a.r1_rdata, tv[i].rd);
        end

        // reset lands on a read-grant cycle; the read must not complete and memory is re-cleared
        @(negedge clk);
        drive(mk(1,0,0,3,0, 0,0,0,0,0, 0,0,0,0,0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rr.rvalid", {a.r1_rvalid, a.r0_rvalid}, 0);
        chk("rr.wenb", a.mem_wenb, 1);
        chk("rr.addr", a.mem_addrb, 0);
        chk("rr.done", done0, 0);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d.addr", k), a.mem_addrb, k - 1);
        end
        @(negedge clk);
        #1;
        chk("rr17.r0_gnt", a.r0_gnt, 1);
        chk("rr17.done", done0, 1);
        @(negedge clk);
        drive(mk(0,0,0,0,0, 1,0,0,5,0, 0,0,0,0,0));
        #1;
        chk("rr18.r0_rvalid", a.r0_rvalid, 1);
        chk("rr18.r0_rdata", a.r0_rdata, 0);
        chk("rr18.r1_gnt", a.r1_gnt, 1);
        @(negedge clk);
        drive(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
        #1;
        chk("rr19.r1_rvalid", a.r1_rvalid, 1);
        chk("rr19.r1_rdata", a.r1_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
